// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection for the 5-stage core.
// Resolves the hazards bypassing cannot cover: load-use, taken-branch
// redirect and multi-cycle data-memory waits. Stage enables and flushes
// are decoded combinationally from the inputs and the MEM-wait FSM. A
// watchdog flags over-long memory waits, and event counters track stalls
// and branch flushes.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic             IFID_rs1_used_i,
  input  logic             IFID_rs2_used_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_rd_wren_i,
  input  logic             IDEX_memrd_i,
  input  logic             branch_taken_i,
  input  logic             EXMEM_memreq_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             IFID_en_o,
  output logic             IFID_flush_o,
  output logic             IDEX_en_o,
  output logic             IDEX_flush_o,
  output logic             EXMEM_en_o,
  output logic             MEMWB_flush_o,
  output logic             mem_wait_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [0:0]       ST_IDLE     = 1'b0;
  localparam logic [0:0]       ST_MEM_WAIT = 1'b1;
  localparam logic [15:0]      TMO_LIM     = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [15:0]      tmo_r;
  logic [15:0]      tmo_nxt_s;
  logic             err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic mem_stall_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;
  logic pc_en_s;
  logic ifid_en_s;
  logic ifid_flush_s;
  logic idex_en_s;
  logic idex_flush_s;
  logic exmem_en_s;
  logic memwb_flush_s;

  // An outstanding access without ack stalls whether or not the FSM has
  // already moved to MEM_WAIT, so a same-cycle ack never stalls.
  assign mem_stall_s = EXMEM_memreq_i & ~dmem_ack_i;
  assign rs1_hit_s   = IFID_rs1_used_i & (IFID_rs1_i == IDEX_rd_i);
  assign rs2_hit_s   = IFID_rs2_used_i & (IFID_rs2_i == IDEX_rd_i);
  // x0 is hardwired to zero, so a load "writing" it can never be a producer.
  assign load_use_s  = IDEX_memrd_i & IDEX_rd_wren_i & (IDEX_rd_i != 5'd0)
                     & (rs1_hit_s | rs2_hit_s);

  // MEM-wait FSM next-state: enter on an un-acked request, leave on ack.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (mem_stall_s) state_nxt_s = ST_MEM_WAIT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_MEM_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Watchdog count of MEM_WAIT cycles including the current one; it holds at
  // the limit so a very long wait cannot wrap back below it.
  always_comb begin
    tmo_nxt_s = 16'd0;
    case (state_r)
      ST_IDLE: begin
        if (mem_stall_s) tmo_nxt_s = 16'd1;
        else             tmo_nxt_s = 16'd0;
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i)            tmo_nxt_s = 16'd0;
        else if (tmo_r < TMO_LIM)  tmo_nxt_s = tmo_r + 16'd1;
        else                       tmo_nxt_s = tmo_r;
      end
      default: tmo_nxt_s = 16'd0;
    endcase
  end

  // Enable/flush decode: memory stall beats branch, branch beats load-use.
  // While reset is held the pipeline sees plain run values.
  always_comb begin
    pc_en_s       = 1'b1;
    ifid_en_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b1;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b1;
    memwb_flush_s = 1'b0;
    if (!rst_ni) begin
      pc_en_s = 1'b1;
    end else if (mem_stall_s) begin
      // Freeze everything up to EX/MEM; a branch in EX redirects after release.
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_en_s    = 1'b0;
      memwb_flush_s = 1'b1;
    end else if (branch_taken_i) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed; this also
      // covers a load-use match since that ID instruction is being discarded.
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      idex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // FSM, watchdog counter and sticky timeout error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      tmo_r   <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tmo_r   <= tmo_nxt_s;
      if (tmo_nxt_s == TMO_LIM) err_r <= 1'b1;
    end
  end

  // Free-running stall and branch-flush event counters (wrap on overflow).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en_s)     stall_cnt_r <= stall_cnt_r + CNT_ONE;
      if (ifid_flush_s) flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end
  end

  assign pc_en_o       = pc_en_s;
  assign IFID_en_o     = ifid_en_s;
  assign IFID_flush_o  = ifid_flush_s;
  assign IDEX_en_o     = idex_en_s;
  assign IDEX_flush_o  = idex_flush_s;
  assign EXMEM_en_o    = exmem_en_s;
  assign MEMWB_flush_o = memwb_flush_s;
  assign mem_wait_o    = (state_r == ST_MEM_WAIT);
  assign err_o         = err_r;
  assign stall_cnt_o   = stall_cnt_r;
  assign flush_cnt_o   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario-driven bench for hazard_ctrl with a scoreboard
// queue of expected output vectors.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wren;
    logic       memrd;
    logic       br;
    logic       memreq;
    logic       ack;
  } stim_t;

  // {pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_flush,
  //  mem_wait, err, stall_cnt, flush_cnt}
  typedef logic [72:0] vec_t;

  localparam logic [7:0] RUN    = 8'b11010100;
  localparam logic [7:0] RUN_MW = 8'b11010101;
  localparam logic [7:0] LU     = 8'b00011100;
  localparam logic [7:0] MEM    = 8'b00000010;
  localparam logic [7:0] MEM_MW = 8'b00000011;
  localparam logic [7:0] BR     = 8'b11111100;
  localparam logic [7:0] BR_MW  = 8'b11111101;
  localparam stim_t      IDLE_S = '0;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, wren, memrd, br, memreq, ack;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic        mem_wait, err;
  logic [31:0] stall_cnt, flush_cnt;

  vec_t        sb[$];
  int          nvec = 0;
  int          nmis = 0;
  logic        e_err = 1'b0;
  logic [31:0] e_stall = 32'd0;
  logic [31:0] e_flush = 32'd0;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
    .IFID_rs1_used_i(u1), .IFID_rs2_used_i(u2),
    .IDEX_rd_i(rd), .IDEX_rd_wren_i(wren), .IDEX_memrd_i(memrd),
    .branch_taken_i(br), .EXMEM_memreq_i(memreq), .dmem_ack_i(ack),
    .pc_en_o(pc_en), .IFID_en_o(ifid_en), .IFID_flush_o(ifid_flush),
    .IDEX_en_o(idex_en), .IDEX_flush_o(idex_flush), .EXMEM_en_o(exmem_en),
    .MEMWB_flush_o(memwb_flush), .mem_wait_o(mem_wait), .err_o(err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input logic [4:0] a1, input logic [4:0] a2,
                               input logic f1, input logic f2, input logic [4:0] d,
                               input logic w, input logic m, input logic b,
                               input logic q, input logic k);
    stim_t s;
    s.rs1 = a1; s.rs2 = a2; s.u1 = f1; s.u2 = f2; s.rd = d;
    s.wren = w; s.memrd = m; s.br = b; s.memreq = q; s.ack = k;
    return s;
  endfunction

  function automatic vec_t observe();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
            memwb_flush, mem_wait, err, stall_cnt, flush_cnt};
  endfunction

  task automatic drive(input stim_t s);
    rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2; rd = s.rd;
    wren = s.wren; memrd = s.memrd; br = s.br; memreq = s.memreq; ack = s.ack;
  endtask

  // Drive one cycle of stimulus and push the expected outputs for it; the
  // counters seen this cycle reflect only earlier cycles.
  task automatic apply(input stim_t s, input logic [7:0] ctl);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back({ctl, e_err, e_stall, e_flush});
    if (ctl[7] == 1'b0) e_stall = e_stall + 32'd1;
    if (ctl[5] == 1'b1) e_flush = e_flush + 32'd1;
  endtask

  task automatic test_reset();
    vec_t got, exp;
    rst_n = 1'b0;
    drive(st(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    #3;
    sb.push_back({RUN, 1'b0, 32'd0, 32'd0});
    got = observe(); exp = sb.pop_front(); nvec++;
    if (got !== exp) begin
      nmis++; $display("FAIL reset_hold got=%h exp=%h", got, exp);
    end
    drive(IDLE_S);
    @(negedge clk);
    rst_n = 1'b1;
    apply(IDLE_S, RUN);
    @(negedge clk);
    got = observe(); exp = sb.pop_front(); nvec++;
    if (got !== exp) begin
      nmis++; $display("FAIL reset_run got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_load_use();
    stim_t      s[4];
    logic [7:0] c[4];
    vec_t       got, exp;
    s[0] = st(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); c[0] = LU;
    s[1] = IDLE_S;                                                          c[1] = RUN;
    s[2] = st(5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); c[2] = LU;
    s[3] = IDLE_S;                                                          c[3] = RUN;
    for (int i = 0; i < 4; i++) begin
      apply(s[i], c[i]);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_no_hazard();
    stim_t s[5];
    vec_t  got, exp;
    s[0] = st(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s[1] = st(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s[2] = st(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    s[3] = st(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s[4] = st(5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i], RUN);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL no_hazard[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t      s[7];
    logic [7:0] c[7];
    vec_t       got, exp;
    s[0] = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); c[0] = MEM;
    s[1] = st(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); c[1] = MEM_MW;
    s[2] = s[1];                                                            c[2] = MEM_MW;
    s[3] = st(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); c[3] = BR_MW;
    s[4] = IDLE_S;                                                          c[4] = RUN;
    s[5] = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); c[5] = RUN;
    s[6] = IDLE_S;                                                          c[6] = RUN;
    for (int i = 0; i < 7; i++) begin
      apply(s[i], c[i]);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch();
    stim_t      s[3];
    logic [7:0] c[3];
    vec_t       got, exp;
    s[0] = st(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); c[0] = BR;
    s[1] = IDLE_S;                                                          c[1] = RUN;
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); c[2] = BR;
    for (int i = 0; i < 3; i++) begin
      apply(s[i], c[i]);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t      s[4];
    logic [7:0] c[4];
    vec_t       got, exp;
    s[0] = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); c[0] = BR;
    s[1] = s[0];                                                            c[1] = BR;
    s[2] = st(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); c[2] = LU;
    s[3] = IDLE_S;                                                          c[3] = RUN;
    for (int i = 0; i < 4; i++) begin
      apply(s[i], c[i]);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t      mreq_s, mack_s;
    stim_t      s[9];
    logic [7:0] c[9];
    vec_t       got, exp;
    mreq_s = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mack_s = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    s[0] = mreq_s; c[0] = MEM;
    for (int i = 1; i < 6; i++) begin
      s[i] = mreq_s; c[i] = MEM_MW;
    end
    s[6] = mack_s; c[6] = RUN_MW;
    s[7] = IDLE_S; c[7] = RUN;
    s[8] = IDLE_S; c[8] = RUN;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) e_err = 1'b1;  // 4th MEM_WAIT cycle
      apply(s[i], c[i]);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL timeout[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t mreq_s;
    vec_t  got, exp;
    mreq_s = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(mreq_s, (i == 0) ? MEM : MEM_MW);
      @(negedge clk);
      got = observe(); exp = sb.pop_front(); nvec++;
      if (got !== exp) begin
        nmis++; $display("FAIL async_pre[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    e_err = 1'b0; e_stall = 32'd0; e_flush = 32'd0;
    sb.push_back({RUN, 1'b0, 32'd0, 32'd0});
    got = observe(); exp = sb.pop_front(); nvec++;
    if (got !== exp) begin
      nmis++; $display("FAIL async_in_reset got=%h exp=%h", got, exp);
    end
    drive(IDLE_S);
    @(negedge clk);
    rst_n = 1'b1;
    apply(IDLE_S, RUN);
    @(negedge clk);
    got = observe(); exp = sb.pop_front(); nvec++;
    if (got !== exp) begin
      nmis++; $display("FAIL async_release got=%h exp=%h", got, exp);
    end
    apply(mreq_s, MEM);
    @(negedge clk);
    got = observe(); exp = sb.pop_front(); nvec++;
    if (got !== exp) begin
      nmis++; $display("FAIL async_restart got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
